uart_rx_os: RTL and testbench
=============================

# uart_rx_os

Parametrised, oversampling UART receiver; successor to the single-sample-per-clock receiver. Recovers asynchronous serial frames from an unsynchronised line using an internal baud-tick divider and OS_RATE× oversampling. Supports configurable data width, runtime parity and stop-bit selection, start-bit glitch rejection, and error reporting. Delivers each word through a valid/ready output register; sits between the pad/loopback line and the consumer FIFO.

## Interface
- DATA_W, 8, data bits per frame, legal 5..9
- OS_RATE, 16, oversample ticks per bit, even, ≥4
- DIV_W, 16, width of baud divider input
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- baud_div  in  DIV_W  oversample tick every baud_div+1 clocks
- rx_in  in  1  serial line, asynchronous, idle high
- par_en  in  1  parity bit present after data
- par_odd  in  1  1 = odd parity, 0 = even
- stop2  in  1  two stop bits expected
- rx_data  out  DATA_W  received word, LSB first on line
- rx_valid  out  1  rx_data/par_err/frame_err valid
- rx_ready  in  1  consumer accepts word when rx_valid & rx_ready
- par_err  out  1  parity mismatch for word in rx_data
- frame_err  out  1  a stop bit sampled low for word in rx_data
- overrun  out  1  one-clock pulse: completed frame dropped
- busy  out  1  high in any state except IDLE

## Operation
- rx_in passes a 2-flop synchroniser (reset value 1); all logic uses synchronised rx_s.
- Tick generator: down-counter loaded with baud_div; tick when 0, then reload. baud_div sampled at each reload.
- Per-bit tick counter os_cnt 0..OS_RATE-1; sample point at os_cnt == OS_RATE/2-1.
- States: IDLE, START, DATA, PARITY, STOP, STOP2.
- IDLE: armed flag set when rx_s == 1 on a tick; armed & rx_s == 0 on a tick → START, os_cnt = 0, armed cleared.
- START: at sample point rx_s == 1 → IDLE (glitch, no output); rx_s == 0 → continue; at os_cnt == OS_RATE-1 → DATA.
- DATA: sample at sample point into shift register (LSB first), bit counter 0..DATA_W-1; after bit DATA_W-1 completes → PARITY if par_en else STOP.
- PARITY: sampled bit XORed with data XOR; par_err = (xor ^ par_odd ^ bit_expected) mismatch, i.e. error when XOR of data and parity bit ≠ par_odd.
- STOP: sample; 0 sets frame_err. After sample point (not full bit) → STOP2 if stop2 else complete; completion at sample point permits back-to-back frames.
- STOP2: same check, completes at its sample point.
- Completion: if !rx_valid or (rx_valid & rx_ready) same clock → load rx_data, par_err, frame_err, assert rx_valid. Otherwise drop new frame, pulse overrun, retain old word. State → IDLE.
- After frame_err, armed is clear; receiver does not restart until line seen high (break tolerance).
- par_en, par_odd, stop2 sampled on the START→DATA transition; changes mid-frame ignored.

## Timing
- Reset: rx_data 0, rx_valid 0, par_err 0, frame_err 0, overrun 0, busy 0, state IDLE, armed 0, synchroniser 1, dividers cleared.
- Reset mid-frame aborts frame; no output, no overrun.
- Input latency: 2 clocks synchroniser.
- rx_valid rises the clock after the final stop-bit sample point; held until handshake; drops the clock after rx_valid & rx_ready unless a new word loads that same clock.
- busy rises the clock after IDLE→START, falls the clock after return to IDLE.
- baud_div = 0: one tick per clock (bit = OS_RATE clocks).
- Simultaneous completion and handshake: new word loads, rx_valid stays high, no overrun.

## Configuration
- UART_RX_MAJORITY_EN defined: each bit value = majority of rx_s at ticks OS_RATE/2-2, -1, and 0 offsets (three consecutive ticks ending one after sample point); decision taken at os_cnt == OS_RATE/2.
- Undefined: single sample at os_cnt == OS_RATE/2-1; decision logic and timing as above.

## Test plan
- baud_div=0, OS_RATE=16, 8N1, send 0xA5, rx_ready=1 → rx_data=0xA5, rx_valid one clock, par_err=0, frame_err=0.
- par_en=1, par_odd=0, send 0x03 with parity bit 1 → rx_data=0x03, par_err=1; same with bit 0 → par_err=0.
- Stop bit driven 0, then line held low 40 bit times → one word, frame_err=1, no further frames until line returns high.
- Low pulse of 5 ticks on idle line → no rx_valid, busy returns 0 after START.
- rx_ready=0, send 0x11 then 0x22 → rx_data=0x11 retained, overrun pulses once; assert rx_ready → rx_valid drops.
- Assert reset midway through DATA of 0x5A, release, send 0x3C → only 0x3C delivered, no error flags.

Source files
------------

// File: rtl/uart_rx_os.sv
// ---------------------------------------------------------------------------
// uart_rx_os -- oversampling UART receiver
//
// Recovers asynchronous serial frames from an unsynchronised, idle-high line.
// An internal divider produces one oversample tick every baud_div+1 clocks.
// Each bit spans OS_RATE ticks and is decided near its centre.
// Frame format: start, DATA_W data bits LSB first, optional parity bit,
// one or two stop bits. Parity and stop options are selectable at run time.
//
// Optional build feature (macro UART_RX_MAJORITY_EN):
//   defined   : each bit is the majority of three consecutive ticks ending
//               one tick after the nominal centre. The decision is taken at
//               os_cnt == OS_RATE/2.
//   undefined : single sample at os_cnt == OS_RATE/2-1.
//
// Parameters:
//   DATA_W  data bits per frame (5..9)
//   OS_RATE oversample ticks per bit (even, >= 4)
//   DIV_W   width of baud_div
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   baud_div   oversample tick every baud_div+1 clocks
//   rx_in      serial line (asynchronous, idle high)
//   par_en     parity bit present after the data bits
//   par_odd    1 = odd parity, 0 = even parity
//   stop2      two stop bits expected
//   rx_data    received word
//   rx_valid   rx_data / par_err / frame_err hold a word
//   rx_ready   consumer accepts the word
//   par_err    parity mismatch for the word in rx_data
//   frame_err  a stop bit was sampled low for the word in rx_data
//   overrun    one-clock pulse: a completed frame was dropped
//   busy       receiver is inside a frame (any state except IDLE)
//
// Output handshake: a word transfers on every clock where rx_valid and
// rx_ready are both high. Once rx_valid is raised, the word and its flags
// stay stable until that transfer happens. A frame completing on the same
// clock as a transfer replaces the word, and rx_valid stays high. A frame
// completing while an untransferred word is held is discarded, and overrun
// pulses for one clock.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_rx_os #(
  parameter int DATA_W  = 8,
  parameter int OS_RATE = 16,
  parameter int DIV_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic              rx_in,
  input  logic              par_en,
  input  logic              par_odd,
  input  logic              stop2,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              par_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int OSW = $clog2(OS_RATE);
  localparam int BCW = $clog2(DATA_W);

`ifdef UART_RX_MAJORITY_EN
  localparam int SAMPLE_PT = OS_RATE / 2;
`else
  localparam int SAMPLE_PT = OS_RATE / 2 - 1;
`endif

  localparam logic [OSW-1:0] SP_CNT   = OSW'(SAMPLE_PT);
  localparam logic [OSW-1:0] LAST_CNT = OSW'(OS_RATE - 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_STOP2  = 3'd5
  } state_t;

  state_t state;
  state_t state_next;

  // -------------------------------------------------------------------------
  // Input synchroniser. Both flops reset to the idle (high) level.
  // -------------------------------------------------------------------------
  logic sync1;
  logic rx_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx_in;
      rx_s  <= sync1;
    end
  end

  // -------------------------------------------------------------------------
  // Oversample tick generator. This is a down-counter that ticks at zero.
  // baud_div is only picked up on reload, so a change takes effect from the
  // next tick period onwards.
  // -------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= baud_div;
    end else begin
      div_cnt <= div_cnt - 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Per-bit tick position and bit decision
  // -------------------------------------------------------------------------
  logic [OSW-1:0] os_cnt;
  logic           at_sp;
  logic           at_end;
  logic           bit_val;

  assign at_sp  = tick && (os_cnt == SP_CNT);
  assign at_end = tick && (os_cnt == LAST_CNT);

`ifdef UART_RX_MAJORITY_EN
  // hist[0] holds rx_s from the previous tick and hist[1] from the tick
  // before that. Together with the current rx_s they cover the three-tick
  // voting window.
  logic [1:0] hist;

  always_ff @(posedge clk) begin
    if (reset) begin
      hist <= 2'b11;
    end else if (tick) begin
      hist <= {hist[0], rx_s};
    end
  end

  assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  // -------------------------------------------------------------------------
  // Frame datapath registers
  // -------------------------------------------------------------------------
  logic              armed;
  logic [BCW-1:0]    bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_en_r;
  logic              par_odd_r;
  logic              stop2_r;
  logic              par_err_acc;
  logic              frame_err_acc;
  logic              frame_done;
  logic              accept;

  // The output register can take a new word when it is empty, or when the
  // word it holds transfers on this same clock.
  assign accept = !rx_valid || rx_ready;

  assign busy = (state != S_IDLE);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    frame_done = 1'b0;
    case (state)
      S_IDLE: begin
        // A falling edge only counts after the line has been seen high.
        // This keeps a held-low (break) line from re-triggering the receiver.
        if (tick && armed && !rx_s) begin
          state_next = S_START;
        end
      end
      S_START: begin
        if (at_sp && bit_val) begin
          // The start bit was not low at its centre, so treat it as a glitch.
          state_next = S_IDLE;
        end else if (at_end) begin
          state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (at_end && (bit_cnt == LAST_BIT)) begin
          state_next = par_en_r ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (at_end) begin
          state_next = S_STOP;
        end
      end
      S_STOP: begin
        // Leave at the sample point instead of the end of the bit. The
        // remaining half bit of idle level then re-arms the edge detector,
        // so back-to-back frames are accepted. os_cnt keeps running, so
        // STOP2 reaches its own sample point one full bit later.
        if (at_sp) begin
          if (stop2_r) begin
            state_next = S_STOP2;
          end else begin
            state_next = S_IDLE;
            frame_done = 1'b1;
          end
        end
      end
      S_STOP2: begin
        if (at_sp) begin
          state_next = S_IDLE;
          frame_done = 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State register and datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      armed         <= 1'b0;
      os_cnt        <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      par_en_r      <= 1'b0;
      par_odd_r     <= 1'b0;
      stop2_r       <= 1'b0;
      par_err_acc   <= 1'b0;
      frame_err_acc <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      par_err       <= 1'b0;
      frame_err     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      state   <= state_next;
      overrun <= 1'b0;

      // Edge-detector arming: set by any high tick while idle, and cleared
      // when the start edge is taken.
      if ((state == S_IDLE) && tick) begin
        if (rx_s) begin
          armed <= 1'b1;
        end else if (armed) begin
          armed <= 1'b0;
        end
      end

      // os_cnt is held at zero while idle, so a frame always begins at zero.
      if (state == S_IDLE) begin
        os_cnt <= '0;
      end else if (tick) begin
        os_cnt <= (os_cnt == LAST_CNT) ? '0 : os_cnt + 1'b1;
      end

      // Frame options are captured once per frame. Changes to them
      // mid-frame have no effect.
      if ((state == S_START) && at_end) begin
        bit_cnt       <= '0;
        par_en_r      <= par_en;
        par_odd_r     <= par_odd;
        stop2_r       <= stop2;
        par_err_acc   <= 1'b0;
        frame_err_acc <= 1'b0;
      end

      if (state == S_DATA) begin
        if (at_sp) begin
          shreg <= {bit_val, shreg[DATA_W-1:1]};
        end
        if (at_end) begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end

      // Error when the XOR of the data and parity bits differs from par_odd.
      if ((state == S_PARITY) && at_sp) begin
        par_err_acc <= (^shreg) ^ bit_val ^ par_odd_r;
      end

      if (((state == S_STOP) || (state == S_STOP2)) && at_sp && !bit_val) begin
        frame_err_acc <= 1'b1;
      end

      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      // The final stop bit decision is folded in directly, because the
      // accumulator only updates on this same clock.
      if (frame_done) begin
        if (accept) begin
          rx_data   <= shreg;
          par_err   <= par_err_acc;
          frame_err <= frame_err_acc | !bit_val;
          rx_valid  <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
`timescale 1ns/1ps
module tb_uart_rx_os;

  localparam int DW   = 8;
  localparam int OS   = 16;
  localparam int DIVW = 16;
  localparam int EW   = DW + 2;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [DIVW-1:0] baud_div;
  logic            rx_in;
  logic            par_en;
  logic            par_odd;
  logic            stop2;
  logic [DW-1:0]   rx_data;
  logic            rx_valid;
  logic            rx_ready;
  logic            par_err;
  logic            frame_err;
  logic            overrun;
  logic            busy;

  uart_rx_os #(.DATA_W(DW), .OS_RATE(OS), .DIV_W(DIVW)) dut (
    .clk       (clk),
    .reset     (reset),
    .baud_div  (baud_div),
    .rx_in     (rx_in),
    .par_en    (par_en),
    .par_odd   (par_odd),
    .stop2     (stop2),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .par_err   (par_err),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  // ---------------------------------------------------------------- bookkeeping
  int n_checks = 0;
  int n_fail   = 0;

  // Expected words in arrival order: {data, par_err, frame_err}
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_exp;

  int hs_cnt   = 0;
  int ovr_cnt  = 0;
  int valid_hi = 0;
  int busy_cnt = 0;

  logic rnd_ready   = 1'b0;
  logic ready_fixed = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (busy)     busy_cnt++;
      if (overrun)  ovr_cnt++;
      if (rx_valid) valid_hi++;
      if (rx_valid && rx_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%0h expected none", {rx_data, par_err, frame_err});
        end else begin
          mon_exp = exp_q.pop_front();
          check("word", 32'({rx_data, par_err, frame_err}), 32'(mon_exp));
        end
      end
    end
  end

  // ---------------------------------------------------------------- consumer
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    rx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) begin
        wait_cnt = rx_valid ? wait_cnt + 1 : 0;
        rx_ready = ($urandom_range(0, 3) == 0) || (wait_cnt > 6);
      end else begin
        wait_cnt = 0;
        rx_ready = ready_fixed;
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic drive_bit(input logic b);
    int n;
    n = OS * (int'(baud_div) + 1);
    rx_in = b;
    repeat (n) @(posedge clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic pen, input logic podd,
                            input logic s2, input logic pbit, input logic st1,
                            input logic st2, input int idle);
    par_en  = pen;
    par_odd = podd;
    stop2   = s2;
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
    if (pen) drive_bit(pbit);
    drive_bit(st1);
    if (s2) drive_bit(st2);
    for (int i = 0; i < idle; i++) drive_bit(1'b1);
  endtask

  // Reference model: the expected word follows from the frame contents alone.
  task automatic rand_frame();
    logic [DW-1:0] d;
    logic pen, podd, s2, badp, st1, st2, pbit, fe, pe;
    int sl, idle;
    d    = DW'($urandom_range(0, 255));
    pen  = 1'($urandom_range(0, 1));
    podd = 1'($urandom_range(0, 1));
    s2   = 1'($urandom_range(0, 1));
    badp = ($urandom_range(0, 3) == 0);
    sl   = $urandom_range(0, 5);
    pbit = (^d) ^ podd ^ badp;
    st1  = (sl != 1);
    st2  = (sl != 2);
    fe   = !st1 || (s2 && !st2);
    pe   = pen && badp;
    exp_q.push_back({d, pe, fe});
    idle = fe ? 2 : $urandom_range(0, 2);
    send_frame(d, pen, podd, s2, pbit, st1, st2, idle);
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- main
  initial begin
    int h0, v0, b0, o0;
    logic [DW-1:0] d5a;

    reset    = 1'b1;
    rx_in    = 1'b1;
    par_en   = 1'b0;
    par_odd  = 1'b0;
    stop2    = 1'b0;
    baud_div = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_rx_data",   32'(rx_data),   32'd0);
    check("rst_rx_valid",  32'(rx_valid),  32'd0);
    check("rst_par_err",   32'(par_err),   32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun",   32'(overrun),   32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    @(posedge clk);
    reset = 1'b0;
    repeat (2) drive_bit(1'b1);

    // 8N1 0xA5, consumer always ready
    v0 = valid_hi;
    h0 = hs_cnt;
    exp_q.push_back({8'hA5, 2'b00});
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    check("t1_valid_cycles", valid_hi - v0, 1);
    check("t1_words", hs_cnt - h0, 1);

    // even parity: 0x03 with parity bit 1 is wrong, with 0 is right
    exp_q.push_back({8'h03, 2'b10});
    send_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1);
    exp_q.push_back({8'h03, 2'b00});
    send_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1);

    // low stop bit followed by a long break, then recovery
    h0 = hs_cnt;
    exp_q.push_back({8'h96, 2'b01});
    send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    repeat (20) drive_bit(1'b0);
    b0 = busy_cnt;
    repeat (20) drive_bit(1'b0);
    check("t3_break_busy", busy_cnt - b0, 0);
    check("t3_break_words", hs_cnt - h0, 1);
    repeat (3) drive_bit(1'b1);
    exp_q.push_back({8'h5E, 2'b00});
    send_frame(8'h5E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1);

    // 5-tick glitch on an idle line
    h0 = hs_cnt;
    b0 = busy_cnt;
    rx_in = 1'b0;
    repeat (5) @(posedge clk);
    rx_in = 1'b1;
    repeat (2) drive_bit(1'b1);
    check("t4_busy_seen", 32'(busy_cnt != b0), 32'd1);
    @(negedge clk);
    check("t4_busy_end", 32'(busy), 32'd0);
    check("t4_no_word", hs_cnt - h0, 0);

    // overrun: consumer stalled across two frames
    ready_fixed = 1'b0;
    repeat (2) @(posedge clk);
    h0 = hs_cnt;
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    @(negedge clk);
    check("t5_valid_held", 32'(rx_valid), 32'd1);
    check("t5_data_kept", 32'(rx_data), 32'h11);
    check("t5_overrun_once", ovr_cnt - o0, 1);
    check("t5_no_transfer", hs_cnt - h0, 0);
    exp_q.push_back({8'h11, 2'b00});
    ready_fixed = 1'b1;
    repeat (4) @(negedge clk);
    check("t5_valid_drop", 32'(rx_valid), 32'd0);
    check("t5_one_transfer", hs_cnt - h0, 1);

    // reset in the middle of a frame
    h0 = hs_cnt;
    o0 = ovr_cnt;
    d5a = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d5a[i]);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    reset = 1'b0;
    rx_in = 1'b1;
    @(negedge clk);
    check("t6_busy_after_rst", 32'(busy), 32'd0);
    check("t6_valid_after_rst", 32'(rx_valid), 32'd0);
    repeat (2) drive_bit(1'b1);
    exp_q.push_back({8'h3C, 2'b00});
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    check("t6_words", hs_cnt - h0, 1);
    check("t6_no_overrun", ovr_cnt - o0, 0);

    // randomized frames, options, rates and consumer stalls
    rnd_ready = 1'b1;
    o0 = ovr_cnt;
    for (int g = 0; g < 5; g++) begin
      baud_div = DIVW'($urandom_range(0, 1));
      repeat (3) drive_bit(1'b1);
      for (int k = 0; k < 8; k++) rand_frame();
    end
    repeat (3) drive_bit(1'b1);
    rnd_ready = 1'b0;
    ready_fixed = 1'b1;
    repeat (20) @(posedge clk);
    check("rand_no_overrun", ovr_cnt - o0, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
